// File: rtl/axis_snapshot_buffer_pkg.sv
// Shared definitions for the AXI-Stream snapshot buffer: FSM encoding and width helper.
package axis_snapshot_buffer_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  function automatic int packed_width(input int num_ch, input int ch_width);
    return num_ch * ch_width;
  endfunction

endpackage

// File: rtl/snapshot_bram_sdp.sv
// Simple dual-port block RAM: one write port, one registered read-first read port.
module snapshot_bram_sdp #(
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  // The array has no reset so it maps onto block RAM; contents survive a reset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rdata_o <= '0;
    else          rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/axis_snapshot_buffer.sv
// Arm/trigger-controlled burst capture of decimated stream words into block RAM, with readback.
module axis_snapshot_buffer
  import axis_snapshot_buffer_pkg::*;
#(
  parameter int CH_WIDTH   = 16,
  parameter int NUM_CH     = 2,
  parameter int DEPTH_LOG2 = 10,
  parameter int DEC_WIDTH  = 16
) (
  input  logic                                      aclk,
  input  logic                                      aresetn,
  input  logic [packed_width(NUM_CH,CH_WIDTH)-1:0]  s_axis_tdata,
  input  logic                                      s_axis_tvalid,
  output logic                                      s_axis_tready,
  input  logic                                      arm,
  input  logic                                      trig_en,
  input  logic                                      trig,
  input  logic [DEC_WIDTH-1:0]                      decimation,
  input  logic [DEPTH_LOG2-1:0]                     rd_addr,
  output logic [packed_width(NUM_CH,CH_WIDTH)-1:0]  rd_data,
  output logic                                      busy,
  output logic                                      done,
  output logic [DEPTH_LOG2:0]                       wr_count
);

  localparam int DW = packed_width(NUM_CH, CH_WIDTH);
  localparam logic [DEPTH_LOG2:0] LAST = (DEPTH_LOG2+1)'((2**DEPTH_LOG2) - 1);

  logic [1:0]            state_q, state_d;
  logic                  arm_q;
  logic [DEPTH_LOG2:0]   wr_count_q, wr_count_d;
  logic [DEC_WIDTH-1:0]  dcnt_q, dcnt_d;
  logic [DEC_WIDTH-1:0]  dec_q, dec_d;
  logic                  arm_rise, fire, last_wr, we;

  assign arm_rise      = arm & ~arm_q;
  assign fire          = s_axis_tvalid & (~trig_en | trig);
  assign last_wr       = (wr_count_q == LAST);
  assign s_axis_tready = 1'b1;
  assign wr_count      = wr_count_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      arm_q      <= 1'b0;
      wr_count_q <= '0;
      dcnt_q     <= '0;
      dec_q      <= '0;
    end else begin
      state_q    <= state_d;
      arm_q      <= arm;
      wr_count_q <= wr_count_d;
      dcnt_q     <= dcnt_d;
      dec_q      <= dec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (arm_rise) state_d = ST_ARMED;
      ST_ARMED:         if (fire) state_d = last_wr ? ST_DONE : ST_CAPTURE;
      ST_CAPTURE:       if (we && last_wr) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
    done = (state_q == ST_DONE);
    we   = ((state_q == ST_ARMED) && fire) ||
           ((state_q == ST_CAPTURE) && s_axis_tvalid && (dcnt_q == dec_q));
  end

  // The decimation ratio is latched with the first stored word so it cannot shift mid-burst.
  always_comb begin
    wr_count_d = wr_count_q;
    dcnt_d     = dcnt_q;
    dec_d      = dec_q;
    if ((state_q == ST_IDLE || state_q == ST_DONE) && arm_rise) begin
      wr_count_d = '0;
      dcnt_d     = '0;
    end
    if (we) wr_count_d = wr_count_q + 1'b1;
    if (state_q == ST_ARMED && fire) begin
      dec_d  = decimation;
      dcnt_d = '0;
    end else if (state_q == ST_CAPTURE && s_axis_tvalid) begin
      dcnt_d = (dcnt_q == dec_q) ? '0 : dcnt_q + 1'b1;
    end
  end

  snapshot_bram_sdp #(.DW(DW), .AW(DEPTH_LOG2)) u_ram (
    .clk_i   (aclk),
    .rst_n_i (aresetn),
    .we_i    (we),
    .waddr_i (wr_count_q[DEPTH_LOG2-1:0]),
    .wdata_i (s_axis_tdata),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

endmodule

// File: tb/tb_axis_snapshot_buffer.sv
// Directed scoreboard bench for axis_snapshot_buffer with a 16-word capture depth.
module tb_axis_snapshot_buffer;
  localparam int CW = 16, NC = 2, DL = 4, DECW = 16, DW = 32;

  logic            aclk = 1'b0;
  logic            aresetn;
  logic [DW-1:0]   s_axis_tdata;
  logic            s_axis_tvalid;
  logic            s_axis_tready;
  logic            arm, trig_en, trig;
  logic [DECW-1:0] decimation;
  logic [DL-1:0]   rd_addr;
  logic [DW-1:0]   rd_data;
  logic            busy, done;
  logic [DL:0]     wr_count;

  always #5 aclk = ~aclk;

  axis_snapshot_buffer #(.CH_WIDTH(CW), .NUM_CH(NC), .DEPTH_LOG2(DL), .DEC_WIDTH(DECW)) dut (
    .aclk(aclk), .aresetn(aresetn), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .arm(arm), .trig_en(trig_en), .trig(trig),
    .decimation(decimation), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
    .wr_count(wr_count)
  );

  typedef struct { int addr; logic [DW-1:0] data; } exp_t;
  exp_t exp_q[$];

  int cmp_cnt = 0, err_cnt = 0;
  int ramp = 0, base = 0;
  logic rd_req = 1'b0, req_d;

  // Channel 1 carries a scrambled copy of the ramp so channel packing is checked too.
  function automatic logic [DW-1:0] word(input int v);
    logic [15:0] lo;
    lo = 16'(v);
    return {lo ^ 16'hA5A5, lo};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_status(input string nm, input logic b, input logic d, input int wc);
    check({nm, "_busy"}, busy, b);
    check({nm, "_done"}, done, d);
    check({nm, "_wr_count"}, wr_count, 64'(wc));
  endtask

  task automatic send(input bit v);
    s_axis_tvalid = v;
    s_axis_tdata  = word(ramp);
    @(negedge aclk);
    rd_req = 1'b0;
    if (v) ramp++;
  endtask

  task automatic arm_pulse(input bit v);
    arm = 1'b1;
    send(v);
    arm = 1'b0;
  endtask

  task automatic rd_issue(input int a, input logic [DW-1:0] e);
    exp_t it;
    it.addr = a;
    it.data = e;
    exp_q.push_back(it);
    rd_addr = DL'(a);
    rd_req  = 1'b1;
  endtask

  task automatic read_chk(input int a, input logic [DW-1:0] e);
    rd_issue(a, e);
    send(1'b0);
  endtask

  // Read monitor: a request sampled on a rising edge is answered by rd_data one edge later.
  always @(posedge aclk) req_d <= rd_req;

  always @(negedge aclk) begin
    if (req_d === 1'b1) begin
      if (exp_q.size() == 0) begin
        cmp_cnt++;
        err_cnt++;
        $display("FAIL rd_unexpected: got %0h expected no read", rd_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check($sformatf("rd[%0d]", e.addr), rd_data, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    aresetn = 1'b0; arm = 1'b0; trig = 1'b0; trig_en = 1'b0; decimation = '0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; rd_addr = '0;
    repeat (5) @(negedge aclk);
    chk_status("rst", 1'b0, 1'b0, 0);
    check("rst_rd_data", rd_data, 0);
    check("tready", s_axis_tready, 1);
    aresetn = 1'b1;
    repeat (100) send(1'b1);
    chk_status("idle", 1'b0, 1'b0, 0);

    // Free-running capture
    arm_pulse(1'b1);
    base = ramp;
    repeat (15) send(1'b1);
    chk_status("fr15", 1'b1, 1'b0, 15);
    send(1'b1);
    chk_status("fr16", 1'b0, 1'b1, 16);
    for (int i = 0; i < 16; i++) read_chk(i, word(base + i));

    // Decimation by 3 with gapped valid; input change after start must be ignored
    decimation = 16'd2;
    arm_pulse(1'b0);
    ramp = 0;
    send(1'b1);
    decimation = 16'd7;
    while (ramp < 45) begin send(1'b0); send(1'b1); end
    chk_status("dec15", 1'b1, 1'b0, 15);
    send(1'b0); send(1'b1);
    chk_status("dec16", 1'b0, 1'b1, 16);
    for (int i = 0; i < 16; i++) read_chk(i, word(3 * i));
    decimation = '0;

    // Triggered capture; trig on an invalid cycle must not fire
    trig_en = 1'b1;
    arm_pulse(1'b1);
    ramp = 90;
    repeat (10) send(1'b1);
    chk_status("armed", 1'b1, 1'b0, 0);
    trig = 1'b1;
    send(1'b0);
    chk_status("trig_inval", 1'b1, 1'b0, 0);
    send(1'b1);
    trig = 1'b0;
    chk_status("trig1", 1'b1, 1'b0, 1);
    repeat (15) send(1'b1);
    chk_status("trig_done", 1'b0, 1'b1, 16);
    read_chk(0, word(100)); read_chk(7, word(107)); read_chk(15, word(115));

    // Rearm from DONE, ignored arm mid-capture, read-first collision at address 3
    trig_en = 1'b0;
    arm_pulse(1'b0);
    chk_status("rearm", 1'b1, 1'b0, 0);
    ramp = 200;
    repeat (3) send(1'b1);
    rd_issue(3, word(103));
    send(1'b1);
    arm_pulse(1'b1);
    repeat (10) send(1'b1);
    chk_status("ign15", 1'b1, 1'b0, 15);
    send(1'b1);
    chk_status("ign16", 1'b0, 1'b1, 16);
    read_chk(0, word(200)); read_chk(3, word(203)); read_chk(15, word(215));

    // Asynchronous abort mid-capture
    arm_pulse(1'b0);
    ramp = 300;
    repeat (7) send(1'b1);
    chk_status("ab7", 1'b1, 1'b0, 7);
    #2 aresetn = 1'b0;
    #1 chk_status("abort", 1'b0, 1'b0, 0);
    check("abort_rd_data", rd_data, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    send(1'b0);
    chk_status("post_abort", 1'b0, 1'b0, 0);
    read_chk(3, word(303));

    repeat (3) @(negedge aclk);
    check("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/axis_snapshot_buffer.md
Name: axis_snapshot_buffer

Overview:
Multi-sample, multi-channel successor to the single-word AXI-Stream snapshot latch. On software arm, with an optional external trigger, it records a burst of 2**DEPTH_LOG2 decimated stream words into internal block RAM. Software reads the captured words back through a random-access read port. It sits on an always-ready ADC-side stream tap in parallel with the main datapath, and is controlled from the register bank.

Parameters:
CH_WIDTH, 16, bits per channel
NUM_CH, 2, channels packed in s_axis_tdata (channel 0 in LSBs)
DEPTH_LOG2, 10, log2 of capture depth in words
DEC_WIDTH, 16, width of decimation control

Ports:
aclk  in  1  clock
aresetn  in  1  reset; asynchronous, active-low
s_axis_tdata  in  NUM_CH*CH_WIDTH  packed sample word
s_axis_tvalid  in  1  sample valid
s_axis_tready  out  1  tied to 1 (tap never stalls)
arm  in  1  capture request, rising-edge sensitive
trig_en  in  1  1 = wait for trig after arm; 0 = start on first valid after arm
trig  in  1  external trigger level, sampled with valid words
decimation  in  DEC_WIDTH  store one of every (decimation+1) valid words
rd_addr  in  DEPTH_LOG2  readback address
rd_data  out  NUM_CH*CH_WIDTH  word at rd_addr, registered
busy  out  1  high in ARMED or CAPTURE
done  out  1  high in DONE
wr_count  out  DEPTH_LOG2+1  words stored in current/last capture

Behaviour:
- Reset (aresetn low, asynchronous): state IDLE; busy=0, done=0, wr_count=0, rd_data=0, decimation counter=0, arm edge register=0. RAM contents are not cleared.
- Edge detect: arm_q is registered each cycle; arm_rise = arm & ~arm_q.
- FSM states: IDLE, ARMED, CAPTURE, DONE.
  - IDLE --arm_rise--> ARMED.
  - DONE --arm_rise--> ARMED. done drops the cycle after arm_rise.
  - ARMED --(s_axis_tvalid & (~trig_en | trig))--> CAPTURE. That qualifying word is stored at address 0 in the same cycle, and wr_count becomes 1.
  - CAPTURE: decimation counter dcnt counts valid words. When tvalid & dcnt==decimation, the word is written at address wr_count, wr_count increments, and dcnt resets to 0. On other valid words, dcnt increments. Invalid cycles hold all state.
  - CAPTURE --(write where wr_count reaches 2**DEPTH_LOG2)--> DONE. wr_count then holds 2**DEPTH_LOG2 (MSB set).
- arm_rise in ARMED or CAPTURE is ignored; there is no restart mid-capture.
- Entering ARMED clears wr_count and dcnt.
- decimation is sampled at the ARMED->CAPTURE transition and held for the whole capture. decimation=0 stores every valid word.
- With trig_en=1, trig is sampled only on cycles with s_axis_tvalid=1. trig high at the moment of arm_rise does not fire until the next valid word in ARMED.
- Read port: rd_data <= ram[rd_addr], 1-cycle latency. Reads are legal in any state. A read/write to the same address in the same cycle returns the old data (read-first).
- s_axis_tready is constant 1; throughput is one word per clock, with no back-pressure.
- Reset asserted mid-capture aborts to IDLE immediately. Stale RAM data stays readable after reset.

Decomposition:
- Shared package: FSM state encoding (2-bit localparams IDLE=0, ARMED=1, CAPTURE=2, DONE=3) and a function computing packed width NUM_CH*CH_WIDTH.
- One sub-module: snapshot_bram_sdp, a simple dual-port RAM with 1 write and 1 registered read, parametrised by data width and address width, inferred as block RAM with no reset on the array.
- FSM, edge detect and counters live in the top level.

Test Plan:
- Reset/idle: hold aresetn low 5 cycles, then release with tvalid=1 and no arm -> busy=0, done=0, wr_count=0 after 100 cycles.
- Free-run capture: DEPTH_LOG2=4, trig_en=0, decimation=0, continuous ramp tdata=0,1,2…; pulse arm -> done rises after exactly 16 valid words; reading addresses 0..15 returns 16 consecutive ramp values starting at the first valid word after arm_rise.
- Decimation with gaps: decimation=2, tvalid toggling 1,0,1,0…, ramp counts valid words only -> stored values are 0,3,6,…,45 and wr_count=16.
- Triggered capture: trig_en=1, trig rises while the ramp is at 100 -> ram[0]=100 (first valid word with trig high), ram[15]=115; busy stays high until then.
- Rearm and ignore: arm pulse during CAPTURE -> no effect, and done rises at the normal count. A second arm pulse in DONE -> done=0 next cycle, wr_count=0, and a new capture overwrites from address 0.
- Async abort: assert aresetn mid-capture at wr_count=7 -> busy=0, done=0, wr_count=0 without waiting for a clock edge. After release, rd_addr=3 still returns the word written before reset.
